// File: rtl/cnn_stream_engine.sv
// Streaming 3x3 valid-padding convolution engine with NUM_OC parallel output
// channels, optional ReLU and optional 2x2/stride-2 max-pool, followed by
// saturation to OUT_WIDTH. Pixels arrive in raster order on a valid/ready
// stream; one registered result leaves per completed window (or pool block).
module cnn_stream_engine #(
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int ACC_WIDTH    = 32,
    parameter int OUT_WIDTH    = 8,
    parameter int IMG_W        = 28,
    parameter int IMG_H        = 28,
    parameter int NUM_OC       = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           start_i,
    input  logic                           relu_en_i,
    input  logic                           pool_en_i,
    input  logic                           wt_we_i,
    input  logic [$clog2(9*NUM_OC)-1:0]    wt_addr_i,
    input  logic signed [WEIGHT_WIDTH-1:0] wt_data_i,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [DATA_WIDTH-1:0]          in_data_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [NUM_OC*OUT_WIDTH-1:0]    out_data_o,
    output logic                           out_last_o,
    output logic                           busy_o,
    output logic                           done_o
);

    localparam int NW    = 9 * NUM_OC;
    localparam int TOTAL = IMG_W * IMG_H;
    localparam int CW    = IMG_W - 2;
    localparam int CH    = IMG_H - 2;
    localparam int PW    = CW / 2;
    localparam int PH    = CH / 2;
    localparam int PBUF  = (PW > 0) ? PW : 1;
    localparam int XW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW    = $clog2(IMG_H + 1);
    localparam int CNTW  = $clog2(TOTAL + 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

    state_t                         r_state, w_state_nxt;
    logic signed [WEIGHT_WIDTH-1:0] r_wt [NW];
    logic                           r_relu, r_pool;
    logic [YW-1:0]                  r_row;
    logic [XW-1:0]                  r_col;
    logic [CNTW-1:0]                r_cnt;
    logic [DATA_WIDTH-1:0]          r_lb0 [IMG_W];
    logic [DATA_WIDTH-1:0]          r_lb1 [IMG_W];
    logic [DATA_WIDTH-1:0]          r_win [3][2];
    logic signed [ACC_WIDTH-1:0]    r_pmax [PBUF][NUM_OC];
    logic                           r_vld_p1, r_last_p1;
    logic [NUM_OC*OUT_WIDTH-1:0]    r_res_p1;

    logic                           w_start, w_accept, w_more;
    logic [DATA_WIDTH-1:0]          w_col [3];
    logic [DATA_WIDTH-1:0]          w_win [9];
    logic signed [ACC_WIDTH-1:0]    w_acc [NUM_OC];
    logic signed [ACC_WIDTH-1:0]    w_act [NUM_OC];
    logic signed [ACC_WIDTH-1:0]    w_val [NUM_OC];
    logic                           w_emit, w_last, w_in_pool;
    int                             w_pidx;
    logic [NUM_OC*OUT_WIDTH-1:0]    w_res_p0;

    function automatic logic signed [ACC_WIDTH-1:0] mul(input logic [DATA_WIDTH-1:0] p,
                                                        input logic signed [WEIGHT_WIDTH-1:0] w);
        logic signed [ACC_WIDTH-1:0] a, b;
        a = ACC_WIDTH'(p);
        b = ACC_WIDTH'(w);
        return a * b;
    endfunction

    function automatic logic signed [ACC_WIDTH-1:0] relu(input logic signed [ACC_WIDTH-1:0] v);
        return v[ACC_WIDTH-1] ? '0 : v;
    endfunction

    function automatic logic signed [ACC_WIDTH-1:0] smax(input logic signed [ACC_WIDTH-1:0] a,
                                                         input logic signed [ACC_WIDTH-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [OUT_WIDTH-1:0] sat(input logic signed [ACC_WIDTH-1:0] v);
        if (v > SAT_MAX) return OUT_WIDTH'(SAT_MAX);
        if (v < SAT_MIN) return OUT_WIDTH'(SAT_MIN);
        return OUT_WIDTH'(v);
    endfunction

    assign w_start  = (r_state == S_IDLE) && start_i;
    assign w_accept = in_valid_i && in_ready_o;
    assign w_more   = (r_cnt < CNTW'(TOTAL));

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // FSM next state: frame ends once every pixel is in and the last result has drained
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start_i) w_state_nxt = S_RUN;
            S_RUN:   if (!w_more && !r_vld_p1) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: input is back-pressured whenever the result register cannot be refilled
    always_comb begin
        busy_o     = (r_state != S_IDLE);
        done_o     = (r_state == S_DONE);
        in_ready_o = (r_state == S_RUN) && w_more && (!r_vld_p1 || out_ready_i);
    end

    // Coefficient store, writable only while idle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NW; i++) r_wt[i] <= '0;
        end else if (r_state == S_IDLE && wt_we_i && int'(wt_addr_i) < NW) begin
            r_wt[wt_addr_i] <= wt_data_i;
        end
    end

    // Mode latch and raster position counters
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_relu <= 1'b0;
            r_pool <= 1'b0;
            r_row  <= '0;
            r_col  <= '0;
            r_cnt  <= '0;
        end else if (w_start) begin
            r_relu <= relu_en_i;
            r_pool <= pool_en_i;
            r_row  <= '0;
            r_col  <= '0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_col == XW'(IMG_W - 1)) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Two-row line buffer plus two-column window shift registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni || w_start) begin
            for (int i = 0; i < IMG_W; i++) begin
                r_lb0[i] <= '0;
                r_lb1[i] <= '0;
            end
            for (int k = 0; k < 3; k++) begin
                r_win[k][0] <= '0;
                r_win[k][1] <= '0;
            end
        end else if (w_accept) begin
            r_lb0[r_col] <= r_lb1[r_col];
            r_lb1[r_col] <= in_data_i;
            for (int k = 0; k < 3; k++) begin
                r_win[k][0] <= r_win[k][1];
                r_win[k][1] <= w_col[k];
            end
        end
    end

    // Stage p0: assemble the 3x3 window (ky=0 oldest row, kx=0 oldest column)
    always_comb begin
        w_col[0] = r_lb0[r_col];
        w_col[1] = r_lb1[r_col];
        w_col[2] = in_data_i;
        for (int k = 0; k < 3; k++) begin
            w_win[k*3 + 0] = r_win[k][0];
            w_win[k*3 + 1] = r_win[k][1];
            w_win[k*3 + 2] = w_col[k];
        end
    end

    // Multiply-accumulate per channel, then optional ReLU
    always_comb begin
        for (int oc = 0; oc < NUM_OC; oc++) begin
            w_acc[oc] = '0;
            for (int k = 0; k < 9; k++) w_acc[oc] = w_acc[oc] + mul(w_win[k], r_wt[oc*9 + k]);
            w_act[oc] = r_relu ? relu(w_acc[oc]) : w_acc[oc];
        end
    end

    // Result selection: direct conv result, or running 2x2 max emitted at the block's last corner
    always_comb begin
        int v_row, v_col, v_idx;
        v_row     = int'(r_row) - 2;
        v_col     = int'(r_col) - 2;
        v_idx     = 0;
        w_emit    = 1'b0;
        w_last    = 1'b0;
        w_in_pool = 1'b0;
        w_pidx    = 0;
        for (int oc = 0; oc < NUM_OC; oc++) w_val[oc] = w_act[oc];
        if (v_row >= 0 && v_col >= 0) begin
            if (!r_pool) begin
                w_emit = 1'b1;
                w_last = (v_row == CH - 1) && (v_col == CW - 1);
            end else if (v_row < 2*PH && v_col < 2*PW) begin
                v_idx     = v_col / 2;
                w_pidx    = v_idx;
                w_in_pool = 1'b1;
                if (v_row % 2 != 0 || v_col % 2 != 0) begin
                    for (int oc = 0; oc < NUM_OC; oc++) w_val[oc] = smax(r_pmax[v_idx][oc], w_act[oc]);
                end
                w_emit = (v_row % 2 == 1) && (v_col % 2 == 1);
                w_last = w_emit && (v_row == 2*PH - 1) && (v_col == 2*PW - 1);
            end
        end
        for (int oc = 0; oc < NUM_OC; oc++) w_res_p0[oc*OUT_WIDTH +: OUT_WIDTH] = sat(w_val[oc]);
    end

    // Partial-max buffer holding one running maximum per pool column
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni || w_start) begin
            for (int i = 0; i < PBUF; i++)
                for (int oc = 0; oc < NUM_OC; oc++) r_pmax[i][oc] <= '0;
        end else if (w_accept && w_in_pool && !w_emit) begin
            for (int oc = 0; oc < NUM_OC; oc++) r_pmax[w_pidx][oc] <= w_val[oc];
        end
    end

    // Stage p1: result register, held while the consumer stalls
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vld_p1  <= 1'b0;
            r_last_p1 <= 1'b0;
            r_res_p1  <= '0;
        end else if (w_accept && w_emit) begin
            r_vld_p1  <= 1'b1;
            r_last_p1 <= w_last;
            r_res_p1  <= w_res_p0;
        end else if (out_ready_i) begin
            r_vld_p1  <= 1'b0;
        end
    end

    assign out_valid_o = r_vld_p1;
    assign out_last_o  = r_last_p1;
    assign out_data_o  = r_res_p1;

endmodule

// File: tb/tb_cnn_stream_engine.sv
// Randomised and directed bench for cnn_stream_engine on a 4x4 image with two
// output channels. Expected results come from a plain 2-D convolution model.
module tb_cnn_stream_engine;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int OC   = 2;
    localparam int NPIX = W * H;
    localparam int NW   = 9 * OC;

    logic        clk = 1'b0;
    logic        rst_n, start, relu_en, pool_en, wt_we;
    logic [4:0]  wt_addr;
    logic [7:0]  wt_data;
    logic        in_valid, in_ready, out_valid, out_ready, out_last, busy, done;
    logic [7:0]  in_data;
    logic [15:0] out_data;

    always #5 clk = ~clk;

    cnn_stream_engine #(
        .DATA_WIDTH(8), .WEIGHT_WIDTH(8), .ACC_WIDTH(32), .OUT_WIDTH(8),
        .IMG_W(W), .IMG_H(H), .NUM_OC(OC)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .relu_en_i(relu_en),
        .pool_en_i(pool_en), .wt_we_i(wt_we), .wt_addr_i(wt_addr), .wt_data_i(wt_data),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .out_last_o(out_last), .busy_o(busy), .done_o(done)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          img [NPIX];
    int          wts [NW];
    int          cap0 [16];
    int          cap1 [16];
    int          capl [16];
    int          cap_n;
    logic [31:0] exp_d [$];
    bit          exp_l [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat8(input int v);
        if (v > 127)  return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    function automatic logic [31:0] pack(input int a0, input int a1);
        logic [7:0] b0, b1;
        b0 = 8'(sat8(a0));
        b1 = 8'(sat8(a1));
        return {16'd0, b1, b0};
    endfunction

    // Reference: full convolution grid, then ReLU, pool and saturation
    task automatic build_model(input bit relu, input bit pool);
        int conv [OC][H-2][W-2];
        int s, m0, m1;
        exp_d.delete();
        exp_l.delete();
        for (int oc = 0; oc < OC; oc++)
            for (int r = 0; r < H - 2; r++)
                for (int c = 0; c < W - 2; c++) begin
                    s = 0;
                    for (int ky = 0; ky < 3; ky++)
                        for (int kx = 0; kx < 3; kx++)
                            s += wts[oc*9 + ky*3 + kx] * img[(r + ky)*W + c + kx];
                    if (relu && s < 0) s = 0;
                    conv[oc][r][c] = s;
                end
        if (!pool) begin
            for (int r = 0; r < H - 2; r++)
                for (int c = 0; c < W - 2; c++) begin
                    exp_d.push_back(pack(conv[0][r][c], conv[1][r][c]));
                    exp_l.push_back(r == H - 3 && c == W - 3);
                end
        end else begin
            for (int pr = 0; pr < (H - 2)/2; pr++)
                for (int pc = 0; pc < (W - 2)/2; pc++) begin
                    m0 = conv[0][2*pr][2*pc];
                    m1 = conv[1][2*pr][2*pc];
                    for (int dy = 0; dy < 2; dy++)
                        for (int dx = 0; dx < 2; dx++) begin
                            if (conv[0][2*pr+dy][2*pc+dx] > m0) m0 = conv[0][2*pr+dy][2*pc+dx];
                            if (conv[1][2*pr+dy][2*pc+dx] > m1) m1 = conv[1][2*pr+dy][2*pc+dx];
                        end
                    exp_d.push_back(pack(m0, m1));
                    exp_l.push_back(pr == (H - 2)/2 - 1 && pc == (W - 2)/2 - 1);
                end
        end
    endtask

    task automatic write_weights();
        for (int i = 0; i < NW; i++) begin
            @(negedge clk);
            wt_we   = 1'b1;
            wt_addr = 5'(i);
            wt_data = 8'(wts[i]);
        end
        @(negedge clk);
        wt_we = 1'b0;
    endtask

    // mode bit0 random valid, bit1 random ready, bit2 five-cycle stall, bit3 illegal writes/start mid-frame
    task automatic run_frame(input bit relu, input bit pool, input int mode);
        int   pix, dones, post, cyc, stall, nexp;
        bit   stalled, prev_hold, prev_last, rdy;
        logic [15:0] prev_data;
        build_model(relu, pool);
        nexp = exp_d.size();
        @(negedge clk);
        relu_en = relu; pool_en = pool; start = 1'b1;
        @(negedge clk);
        start = 1'b0; relu_en = 1'b0; pool_en = 1'b0;
        chk("busy_run", busy, 1);
        pix = 0; dones = 0; post = 0; cyc = 0; stall = 0; cap_n = 0;
        stalled = 0; prev_hold = 0; prev_last = 0; prev_data = '0;
        while (cyc < 3000 && post < 3) begin
            in_valid = 1'b0; wt_we = 1'b0; start = 1'b0;
            if (mode[2] && out_valid && !stalled) begin stall = 5; stalled = 1; end
            rdy = mode[1] ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (stall > 0) begin rdy = 1'b0; stall--; end
            out_ready = rdy;
            #1;
            if (prev_hold) begin
                chk("hold_data", out_data, prev_data);
                chk("hold_last", out_last, prev_last);
            end
            if (out_valid && !out_ready) chk("stall_inrdy", in_ready, 0);
            if (done) dones++;
            if (dones > 0) post++;
            if (out_valid && out_ready) begin
                if (exp_d.size() > 0) begin
                    chk("out_data", out_data, exp_d.pop_front());
                    chk("out_last", out_last, exp_l.pop_front());
                end else begin
                    chk("extra_out", out_valid, 0);
                end
                if (cap_n < 16) begin
                    cap0[cap_n] = $signed(out_data[7:0]);
                    cap1[cap_n] = $signed(out_data[15:8]);
                    capl[cap_n] = out_last;
                end
                cap_n++;
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            prev_last = out_last;
            if (pix < NPIX && (!mode[0] || $urandom_range(0, 2) != 0)) begin
                in_valid = 1'b1;
                in_data  = 8'(img[pix]);
            end
            if (mode[3] && pix == 6) begin
                wt_we = 1'b1; wt_addr = 5'd4; wt_data = 8'd77; start = 1'b1;
            end
            if (in_valid && in_ready) pix++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0; wt_we = 1'b0; start = 1'b0; out_ready = 1'b1;
        chk("done_pulses", dones, 1);
        chk("out_count", cap_n, nexp);
        chk("busy_idle", busy, 0);
    endtask

    task automatic reset_abort_test();
        int pix, cyc;
        for (int i = 0; i < NW; i++) wts[i] = $urandom_range(0, 255) - 128;
        for (int i = 0; i < NPIX; i++) img[i] = i;
        write_weights();
        @(negedge clk);
        relu_en = 1'b1; pool_en = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; relu_en = 1'b0; pool_en = 1'b0; out_ready = 1'b1;
        pix = 0; cyc = 0;
        while (pix < 7 && cyc < 100) begin
            in_valid = 1'b1; in_data = 8'(img[pix]);
            #1;
            if (in_ready) pix++;
            @(negedge clk);
            cyc++;
        end
        chk("abort_pix", pix, 7);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_inrdy", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 8'd200;
            #1;
            chk("post_rst_valid", out_valid, 0);
            chk("post_rst_inrdy", in_ready, 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        // weights were cleared by reset, so a frame now yields all-zero results
        for (int i = 0; i < NW; i++) wts[i] = 0;
        for (int i = 0; i < NPIX; i++) img[i] = $urandom_range(0, 255);
        run_frame(1'b0, 1'b0, 3);
    endtask

    initial begin
        int e0 [4];
        int e1 [4];
        rst_n = 1'b0; start = 1'b0; relu_en = 1'b0; pool_en = 1'b0; wt_we = 1'b0;
        wt_addr = '0; wt_data = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("reset_valid", out_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_data", out_data, 0);
        chk("reset_inrdy", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // centre tap on oc0, box filter on oc1
        for (int i = 0; i < NW; i++) wts[i] = (i >= 9) ? 1 : 0;
        wts[4] = 1;
        for (int i = 0; i < NPIX; i++) img[i] = i;
        write_weights();
        run_frame(1'b0, 1'b0, 0);
        e0 = '{5, 6, 9, 10};
        e1 = '{45, 54, 81, 90};
        for (int i = 0; i < 4; i++) begin
            chk("t1_oc0", cap0[i], e0[i]);
            chk("t1_oc1", cap1[i], e1[i]);
        end
        chk("t1_last3", capl[3], 1);
        chk("t1_last0", capl[0], 0);

        run_frame(1'b0, 1'b1, 0);
        chk("pool_n", cap_n, 1);
        chk("pool_oc0", cap0[0], 10);
        chk("pool_oc1", cap1[0], 90);
        chk("pool_last", capl[0], 1);

        // negative centre tap, with and without ReLU
        wts[4] = -1;
        write_weights();
        run_frame(1'b0, 1'b0, 0);
        e0 = '{-5, -6, -9, -10};
        for (int i = 0; i < 4; i++) chk("neg_oc0", cap0[i], e0[i]);
        run_frame(1'b1, 1'b0, 0);
        for (int i = 0; i < 4; i++) chk("relu_oc0", cap0[i], 0);

        // saturation at both rails
        for (int i = 0; i < NPIX; i++) img[i] = 255;
        for (int i = 0; i < NW; i++) wts[i] = 127;
        write_weights();
        run_frame(1'b0, 1'b0, 1);
        chk("satp_oc0", cap0[0], 127);
        chk("satp_oc1", cap1[3], 127);
        for (int i = 0; i < NW; i++) wts[i] = -128;
        write_weights();
        run_frame(1'b0, 1'b0, 2);
        chk("satn_oc0", cap0[2], -128);
        chk("satn_oc1", cap1[1], -128);

        // consumer stall and ignored mid-frame writes/start
        for (int i = 0; i < NPIX; i++) img[i] = $urandom_range(0, 255);
        for (int i = 0; i < NW; i++) wts[i] = $urandom_range(0, 255) - 128;
        write_weights();
        run_frame(1'b0, 1'b0, 4);
        run_frame(1'b1, 1'b0, 8 + 3);
        run_frame(1'b0, 1'b0, 0);

        // randomised frames
        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < NPIX; i++) img[i] = $urandom_range(0, 255);
            for (int i = 0; i < NW; i++) wts[i] = $urandom_range(0, 255) - 128;
            if (t % 3 == 0) for (int i = 0; i < NW; i++) wts[i] = $urandom_range(0, 8) - 4;
            write_weights();
            run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3);
        end

        reset_abort_test();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
